// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writable instruction memory with a length-prefixed,
// checksummed byte-stream boot loader. The core is held in reset until a
// complete image has been received and its checksum verified. The fetch
// port is the combinational 32-bit little-endian read the core expects.
module instr_mem_loader #(
  parameter int MEM_BYTES = 96,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      Instr_Addr,
  output logic [31:0]      Instruction,
  output logic             core_reset,
  output logic             load_done,
  output logic             load_error,
  output logic [LEN_W-1:0] byte_count
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [LEN_W-1:0] CAP_LEN  = LEN_W'(MEM_BYTES);
  localparam logic [64:0]      CAP_ADDR = 65'(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             xfer;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] length;
  logic [LEN_W-1:0] hdr_len;
  logic [LEN_W-1:0] count_inc;
  logic [7:0]       csum;
  logic [AW-1:0]    wr_idx;
  logic [7:0]       mem [MEM_BYTES];

  assign xfer      = in_valid && in_ready;
  assign hdr_len   = LEN_W'({in_data, len_lo});
  assign count_inc = byte_count + LEN_W'(1);
  assign wr_idx    = byte_count[AW-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: bytes only advance the loader on a valid/ready transfer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = LEN_LO;
      LEN_LO:            if (xfer) state_nxt = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (hdr_len > CAP_LEN)    state_nxt = ERROR;
          else if (hdr_len == '0)   state_nxt = CHECK;
          else                      state_nxt = LOAD;
        end
      end
      LOAD:  if (xfer && count_inc == length) state_nxt = CHECK;
      CHECK: if (xfer) state_nxt = (in_data == csum) ? DONE : ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    in_ready   = 1'b0;
    core_reset = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      LEN_LO, LEN_HI, LOAD, CHECK: in_ready = 1'b1;
      DONE: begin
        core_reset = 1'b0;
        load_done  = 1'b1;
      end
      ERROR: load_error = 1'b1;
      default: ;
    endcase
  end

  // Loader datapath: header length, payload count and running checksum
  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo     <= '0;
      length     <= '0;
      byte_count <= '0;
      csum       <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            byte_count <= '0;
            csum       <= '0;
          end
        end
        LEN_LO: if (xfer) len_lo <= in_data;
        LEN_HI: if (xfer) length <= hdr_len;
        LOAD: begin
          if (xfer) begin
            csum       <= csum + in_data;
            byte_count <= count_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Instruction array write; contents survive reset and new loads
  always_ff @(posedge clk) begin
    if (!reset && state == LOAD && xfer) mem[wr_idx] <= in_data;
  end

  // Fetch port: 65-bit byte addresses so the top of the 64-bit space never
  // wraps back onto the array
  always_comb begin
    logic [64:0] a;
    Instruction = '0;
    a = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      a = {1'b0, Instr_Addr} + 65'(i);
      if (a < CAP_ADDR) Instruction[8*i +: 8] = mem[a[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: header/payload/checksum streams,
// length and checksum error paths, gapped full-capacity load, fetch-port
// boundaries, reset mid-load and reset/start priority.
module tb_instr_mem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] Instr_Addr;
  logic [31:0] Instruction;
  logic        core_reset;
  logic        load_done;
  logic        load_error;
  logic [15:0] byte_count;

  int passed = 0;
  int total  = 0;

  logic [7:0] img [96];
  logic [7:0] sum;

  instr_mem_loader #(.MEM_BYTES(96), .LEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Instr_Addr (Instr_Addr),
    .Instruction(Instruction),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present a byte and hold it until the cycle it is accepted
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic crst,
                            input logic dn, input logic er);
    chk({tag, "_ready"},  {63'b0, in_ready},   {63'b0, rdy});
    chk({tag, "_corerst"}, {63'b0, core_reset}, {63'b0, crst});
    chk({tag, "_done"},   {63'b0, load_done},  {63'b0, dn});
    chk({tag, "_error"},  {63'b0, load_error}, {63'b0, er});
  endtask

  task automatic chk_fetch(input string tag, input logic [63:0] addr, input logic [31:0] exp);
    Instr_Addr = addr;
    #1;
    chk(tag, {32'b0, Instruction}, {32'b0, exp});
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    Instr_Addr = '0;
    tick();
    tick();
    chk_status("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_count", {48'b0, byte_count}, 64'd0);
    reset = 1'b0;
    tick();

    // Basic 4-byte image, checksum 0x13+0x0B = 0x1E
    pulse_start();
    chk_status("lenlo", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h04); send(8'h00);
    send(8'h13); send(8'h0B); send(8'h00); send(8'h00);
    chk("check_count", {48'b0, byte_count}, 64'd4);
    send(8'h1E);
    chk_status("ok1", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ok1_count", {48'b0, byte_count}, 64'd4);
    chk_fetch("ok1_word0", 64'd0, 32'h0000_0B13);

    // Same image, bad checksum
    pulse_start();
    chk_status("restart", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h04); send(8'h00);
    send(8'h13); send(8'h0B); send(8'h00); send(8'h00);
    send(8'h1F);
    chk_status("badsum", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("badsum_sticky", {63'b0, load_error}, 64'd1);

    // Recovery: AA+BB+CC+DD = 0x30E -> 0x0E
    pulse_start();
    chk_status("recov_clr", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h04); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h0E);
    chk_status("recov", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_fetch("recov_word0", 64'd0, 32'hDDCC_BBAA);

    // Length 97 exceeds capacity
    pulse_start();
    send(8'h61); send(8'h00);
    chk_status("len97", 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    chk("len97_ready_low", {63'b0, in_ready}, 64'd0);
    chk("len97_count", {48'b0, byte_count}, 64'd0);

    // Zero-length image, good then bad checksum
    pulse_start();
    send(8'h00); send(8'h00);
    chk("len0_in_check", {63'b0, in_ready}, 64'd1);
    send(8'h00);
    chk_status("len0_ok", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("len0_count", {48'b0, byte_count}, 64'd0);
    pulse_start();
    send(8'h00); send(8'h00);
    send(8'h01);
    chk_status("len0_bad", 1'b0, 1'b1, 1'b0, 1'b1);

    // Full 96-byte image with random valid gaps
    sum = 8'h00;
    for (int i = 0; i < 96; i++) begin
      img[i] = 8'(i * 7 + 3);
      sum    = sum + img[i];
    end
    pulse_start();
    send(8'h60); send(8'h00);
    for (int i = 0; i < 96; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      send(img[i]);
    end
    chk("full_count", {48'b0, byte_count}, 64'd96);
    send(sum);
    chk_status("full", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int a = 0; a < 96; a += 4)
      chk_fetch("full_word", 64'(a), {img[a+3], img[a+2], img[a+1], img[a]});
    chk_fetch("full_a94", 64'd94, {8'h00, 8'h00, img[95], img[94]});
    chk_fetch("full_a95", 64'd95, {24'h0, img[95]});
    chk_fetch("full_a96", 64'd96, 32'h0);
    chk_fetch("full_top", 64'hFFFF_FFFF_FFFF_FFFE, 32'h0);

    // Reset after 10 payload bytes of a 20-byte image
    pulse_start();
    send(8'h14); send(8'h00);
    for (int i = 0; i < 10; i++) begin
      send(8'(8'h50 + i));
      if (i == 4) begin
        pulse_start();
        chk("start_ignored_count", {48'b0, byte_count}, 64'd5);
        chk("start_ignored_ready", {63'b0, in_ready}, 64'd1);
      end
    end
    chk("mid_count", {48'b0, byte_count}, 64'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_status("midrst", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("midrst_count", {48'b0, byte_count}, 64'd0);
    chk_fetch("midrst_w0", 64'd0, 32'h5352_5150);
    chk_fetch("midrst_w4", 64'd4, 32'h5756_5554);
    chk_fetch("midrst_w8", 64'd8, {img[11], img[10], 8'h59, 8'h58});

    // reset and start together: reset wins, block stays idle
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk_status("rst_start", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rst_start_idle", {63'b0, in_ready}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
